sfu_ctrl: RTL and testbench

Sequencer for the special-function unit (accumulate + ReLU). Reads partial sums from psum memory in the order the SFU needs them and drives the SFU's `acc_i`/`mode_i` with cycle-exact alignment. Writes each finished output into output memory. Sits between the top-level core FSM, which issues `start` and waits for `done`, and the psum-memory / SFU / output-memory datapath.

---
 rtl/sfu_ctrl_if.sv | 30 +++
 rtl/sfu_ctrl.sv | 134 +++++++++++++
 tb/tb_sfu_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sfu_ctrl_if.sv
// rtl/sfu_ctrl_if.sv - command, psum-read, SFU-control and output-write signals of the SFU sequencer
interface sfu_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              mode_i;
    logic [CNT_W-1:0]  n_out;
    logic [CNT_W-1:0]  n_kij;
    logic              hold_i;
    logic              busy;
    logic              done;
    logic              pmem_rd;
    logic [ADDR_W-1:0] pmem_addr;
    logic              psum_vld;
    logic              sfu_acc;
    logic              sfu_mode;
    logic              omem_wr;
    logic [ADDR_W-1:0] omem_addr;

    modport master (
        output start, mode_i, n_out, n_kij, hold_i,
        input  busy, done, pmem_rd, pmem_addr, psum_vld, sfu_acc, sfu_mode, omem_wr, omem_addr
    );

    modport slave (
        input  start, mode_i, n_out, n_kij, hold_i,
        output busy, done, pmem_rd, pmem_addr, psum_vld, sfu_acc, sfu_mode, omem_wr, omem_addr
    );
endinterface

// File: rtl/sfu_ctrl.sv
// rtl/sfu_ctrl.sv - sequences psum reads into the accumulate/ReLU SFU and writes finished outputs
module sfu_ctrl #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 8,
    parameter int WB_DLY = 2
) (
    input  logic      clk,
    input  logic      reset,
    sfu_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OS_RD = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int              WC_W      = (WB_DLY > 1) ? $clog2(WB_DLY) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WB_DLY - 1);

    logic [2:0]        r_state;
    logic              r_sfu_mode;
    logic [CNT_W-1:0]  r_n_out;
    logic [CNT_W-1:0]  r_n_kij;
    logic [CNT_W-1:0]  r_o;
    logic [CNT_W-1:0]  r_kij;
    logic [WC_W-1:0]   r_wcnt;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_psum_vld;
    logic              r_sfu_acc;
    logic              r_omem_wr;
    logic [ADDR_W-1:0] r_omem_addr;

    logic              w_os_rd;
    logic              w_pmem_rd;
    logic [ADDR_W-1:0] w_pmem_addr;
    logic              w_wait_last;
    logic              w_kij_last;
    logic              w_zero_run;

    // In OS the o==n_out pass through OS_RD is the drain cycle that lets the last write land.
    assign w_os_rd     = (r_state == S_OS_RD) && (r_o != r_n_out) && !bus.hold_i;
    assign w_pmem_rd   = (r_state == S_RD) || w_os_rd;
    assign w_pmem_addr = (r_state == S_RD) ? r_ptr : (w_os_rd ? ADDR_W'(r_o) : '0);
    assign w_wait_last = (r_state == S_WAIT) && (r_wcnt == WAIT_LAST);
    assign w_kij_last  = (r_kij == r_n_kij - CNT_W'(1));
    assign w_zero_run  = (bus.n_out == '0) || (!bus.mode_i && (bus.n_kij == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sfu_mode  <= 1'b0;
            r_n_out     <= '0;
            r_n_kij     <= '0;
            r_o         <= '0;
            r_kij       <= '0;
            r_wcnt      <= '0;
            r_ptr       <= '0;
            r_psum_vld  <= 1'b0;
            r_sfu_acc   <= 1'b0;
            r_omem_wr   <= 1'b0;
            r_omem_addr <= '0;
        end else begin
            r_psum_vld <= w_pmem_rd;
            r_sfu_acc  <= (r_state == S_RD);
            r_omem_wr  <= w_wait_last || w_os_rd;
            if (w_wait_last || w_os_rd) begin
                r_omem_addr <= ADDR_W'(r_o);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sfu_mode <= bus.mode_i;
                        r_n_out    <= bus.n_out;
                        r_n_kij    <= bus.n_kij;
                        r_o        <= '0;
                        r_state    <= w_zero_run ? S_FIN : S_GAP;
                    end
                end
                S_GAP: begin
                    // Completion is tested before hold so a held core cannot stall the final done.
                    if (r_sfu_mode) begin
                        r_state <= S_OS_RD;
                    end else if (r_o == r_n_out) begin
                        r_state <= S_FIN;
                    end else if (!bus.hold_i) begin
                        r_ptr   <= ADDR_W'(r_o);
                        r_kij   <= '0;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_ptr <= r_ptr + ADDR_W'(r_n_out);
                    r_kij <= r_kij + CNT_W'(1);
                    if (w_kij_last) begin
                        r_wcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt + WC_W'(1);
                    if (w_wait_last) begin
                        r_o     <= r_o + CNT_W'(1);
                        r_state <= S_GAP;
                    end
                end
                S_OS_RD: begin
                    if (r_o == r_n_out) begin
                        r_state <= S_FIN;
                    end else if (!bus.hold_i) begin
                        r_o <= r_o + CNT_W'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_FIN);
    assign bus.pmem_rd   = w_pmem_rd;
    assign bus.pmem_addr = w_pmem_addr;
    assign bus.psum_vld  = r_psum_vld;
    assign bus.sfu_acc   = r_sfu_acc;
    assign bus.sfu_mode  = r_sfu_mode;
    assign bus.omem_wr   = r_omem_wr;
    assign bus.omem_addr = r_omem_addr;
endmodule

// File: tb/tb_sfu_ctrl.sv
// tb/tb_sfu_ctrl.sv - scoreboard bench for sfu_ctrl: per-cycle read/valid/acc/write/done events
module tb_sfu_ctrl;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 8;
    localparam int WB_DLY = 2;
    localparam int K_RD = 0, K_VLD = 1, K_ACC = 2, K_WR = 3, K_DONE = 4;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    logic mon_en;
    logic exp_mode;
    ev_t  q [5][$];
    string nm [5] = '{"rd", "vld", "acc", "wr", "done"};

    sfu_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    sfu_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .WB_DLY(WB_DLY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int outs();
        return int'({bus.busy, bus.done, bus.pmem_rd, bus.pmem_addr, bus.psum_vld,
                     bus.sfu_acc, bus.sfu_mode, bus.omem_wr, bus.omem_addr});
    endfunction

    function automatic void push(input int k, input int c, input int a);
        ev_t e;
        e.cyc  = c;
        e.addr = a;
        q[k].push_back(e);
    endfunction

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < 5; k++) n += q[k].size();
        return n;
    endfunction

    always @(negedge clk) begin : mon
        logic [4:0] obs;
        ev_t        e;
        if (mon_en && !reset) begin
            obs = {bus.done, bus.omem_wr, bus.sfu_acc, bus.psum_vld, bus.pmem_rd};
            for (int k = 0; k < 5; k++) begin
                if (obs[k]) begin
                    if (q[k].size() == 0) begin
                        chk({nm[k], "_extra"}, 1, 0);
                    end else begin
                        e = q[k].pop_front();
                        chk({nm[k], "_cyc"}, cyc, e.cyc);
                        if (k == K_RD)   chk("rd_addr", int'(bus.pmem_addr), e.addr);
                        if (k == K_WR)   chk("wr_addr", int'(bus.omem_addr), e.addr);
                        if (k == K_DONE) begin
                            chk("busy_at_done", int'(bus.busy), 1);
                            chk("mode_at_done", int'(bus.sfu_mode), int'(exp_mode));
                        end
                    end
                end else if (q[k].size() != 0 && q[k][0].cyc <= cyc) begin
                    e = q[k].pop_front();
                    chk({nm[k], "_miss"}, cyc, e.cyc);
                end
            end
        end
    end

    // md: mode, no/nk: n_out/n_kij, hold active on cycles s+hlo..s+hhi-1,
    // mid: offset of an ignored extra start (0 = none), rst_off: offset of a reset (0 = none).
    task automatic run(input logic md, input int no, input int nk, input int hlo, input int hhi,
                       input int mid, input int rst_off);
        int s, t, dn;
        @(posedge clk); #1;
        s = cyc;
        mon_en = 1'b1;
        exp_mode = md;
        bus.start = 1'b1; bus.mode_i = md; bus.n_out = CNT_W'(no); bus.n_kij = CNT_W'(nk); bus.hold_i = 1'b0;
        if (no == 0 || (!md && nk == 0)) begin
            dn = s + 1;
        end else if (!md) begin
            t = s + 1;
            for (int o = 0; o < no; o++) begin
                while (t >= s + hlo && t < s + hhi) t++;
                for (int k = 0; k < nk; k++) begin
                    push(K_RD, t + 1 + k, (o + k * no) % (1 << ADDR_W));
                    push(K_VLD, t + 2 + k, 0);
                    push(K_ACC, t + 2 + k, 0);
                end
                push(K_WR, t + 1 + nk + WB_DLY, o);
                t = t + 1 + nk + WB_DLY;
            end
            dn = t + 1;
        end else begin
            t = s + 2;
            for (int o = 0; o < no; o++) begin
                while (t >= s + hlo && t < s + hhi) t++;
                push(K_RD, t, o);
                push(K_VLD, t + 1, 0);
                push(K_WR, t + 1, o);
                t++;
            end
            dn = t + 1;
        end
        push(K_DONE, dn, 0);
        forever begin
            @(posedge clk); #1;
            bus.start  = (mid != 0 && cyc == s + mid);
            if (bus.start) begin
                bus.mode_i = ~md;
                bus.n_out  = CNT_W'(no + 3);
                bus.n_kij  = CNT_W'(nk + 1);
            end
            bus.hold_i = (cyc >= s + hlo && cyc < s + hhi);
            if (rst_off != 0 && cyc == s + rst_off) begin
                chk("rd_before_rst", int'(bus.pmem_rd), 1);
                mon_en = 1'b0;
                for (int k = 0; k < 5; k++) q[k].delete();
                reset = 1'b1;
                #2;
                chk("rst_mid_outs", outs(), 0);
                bus.start = 1'b0; bus.hold_i = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (cyc > dn + 1) break;
            if (cyc > s + 5000) begin
                chk("timeout", cyc, dn);
                break;
            end
        end
        chk("sb_empty", pending(), 0);
        for (int k = 0; k < 5; k++) q[k].delete();
    endtask

    initial begin
        total = 0; bad = 0; mon_en = 1'b0; exp_mode = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.mode_i = 1'b0; bus.n_out = '0; bus.n_kij = '0; bus.hold_i = 1'b0;
        #3;
        chk("reset_outs", outs(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 0);

        run(1'b0, 2, 3, 0, 0, 0, 0);
        run(1'b1, 4, 0, 0, 0, 0, 0);
        run(1'b0, 2, 3, 7, 12, 0, 0);
        run(1'b0, 2, 3, 1, 6, 0, 0);
        run(1'b1, 6, 0, 3, 6, 0, 0);
        run(1'b1, 5, 0, 4, 5, 0, 0);
        run(1'b0, 0, 3, 0, 0, 0, 0);
        run(1'b0, 3, 0, 0, 0, 0, 0);
        run(1'b1, 0, 0, 0, 0, 0, 0);
        run(1'b0, 1, 1, 0, 0, 0, 0);
        run(1'b1, 1, 0, 0, 0, 0, 0);
        run(1'b0, 3, 2, 0, 0, 4, 0);
        run(1'b1, 5, 0, 0, 0, 3, 0);
        run(1'b0, 200, 12, 0, 0, 0, 0);
        run(1'b0, 3, 4, 0, 0, 0, 4);
        run(1'b0, 2, 2, 0, 0, 0, 0);
        run(1'b1, 3, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
